wb_stage_reg: RTL
=================

Name: wb_stage_reg

Overview:
- Parametrised MEM/WB pipeline register, successor to the single-lane version.
- Supports LANES parallel GPR write lanes, plus HI/LO, LLbit and CP0 write fields.
- Adds flush, a per-lane valid bit, same-cycle write-conflict resolution, and retire/bubble counters.
- Sits between the MEM stage and the regfile/hilo/LLbit/CP0 write ports; driven by the ctrl block's stall vector and exception flush.

Parameters:
- DATA_W, 32, GPR/HI/LO/CP0 data width.
- ADDR_W, 5, GPR address width.
- LANES, 1, number of writeback lanes (1..4); lane LANES-1 is youngest.
- STALL_W, 6, width of the stall vector.
- STAGE, 4, index of this stage's bit in stall; STAGE+1 must be < STALL_W.
- CNT_W, 32, width of the retire and bubble counters.

Ports:
- clk, in, 1, clock; all state changes on the posedge.
- rst, in, 1, synchronous reset, active-high.
- stall, in, STALL_W, pipeline stall vector from ctrl.
- flush, in, 1, exception flush; kills the instruction being captured.
- mem_valid, in, LANES, lane holds a real instruction.
- mem_wreg, in, LANES, GPR write enable per lane.
- mem_dest_addr, in, LANES*ADDR_W, packed GPR address; lane i at [i*ADDR_W +: ADDR_W].
- mem_dest_data, in, LANES*DATA_W, packed GPR write data.
- mem_whilo, in, 1, HI/LO write enable.
- mem_hi, in, DATA_W, HI data.
- mem_lo, in, DATA_W, LO data.
- mem_llbit_we, in, 1, LLbit write enable.
- mem_llbit_data, in, 1, LLbit value.
- mem_cp0_we, in, 1, CP0 write enable.
- mem_cp0_addr, in, 5, CP0 register address.
- mem_cp0_data, in, DATA_W, CP0 write data.
- wb_valid, out, LANES, registered mem_valid.
- wb_wreg, out, LANES, registered and conflict-resolved write enable.
- wb_dest_addr, out, LANES*ADDR_W, registered address.
- wb_dest_data, out, LANES*DATA_W, registered data.
- wb_whilo, wb_hi, wb_lo, out, 1/DATA_W/DATA_W, registered HI/LO fields.
- wb_llbit_we, wb_llbit_data, out, 1/1, registered LLbit fields.
- wb_cp0_we, wb_cp0_addr, wb_cp0_data, out, 1/5/DATA_W, registered CP0 fields.
- retire_cnt, out, CNT_W, count of instructions captured into WB.
- bubble_cnt, out, CNT_W, count of bubbles inserted.

Behaviour:
- Latency: exactly one cycle from mem_* inputs to wb_* outputs. No combinational input-to-output paths.
- Per-posedge priority, highest first:
  1. rst
  2. flush
  3. bubble
  4. advance
  5. hold
- Reset/clear value (used by rst, flush and bubble): all enables and valid bits 0, addresses 0, all data 0, wb_llbit_data 0.
- rst: all outputs take the clear value and both counters go to 0.
- flush: all wb_* outputs take the clear value and counters are unchanged. Flush wins over any stall combination, including stall[STAGE] with stall[STAGE+1] both set.
- bubble: condition is stall[STAGE]=1 and stall[STAGE+1]=0.
  - wb_* outputs take the clear value.
  - bubble_cnt increments by 1.
- advance: condition is stall[STAGE]=0. All mem_* fields are captured, including mem_llbit_we and mem_llbit_data. The following rules apply at capture:
  - Invalid-lane gating: for a lane with mem_valid=0, captured wreg is 0; data and addr are still captured.
  - $0 suppression: a lane with addr==0 captures wreg=0.
  - Same-cycle conflict: if lanes i<j both have valid=1, wreg=1 and equal nonzero addr, lane i captures wreg=0 (the youngest lane wins).
  - HI/LO, LLbit and CP0 enables are captured unchanged; they have no valid gating, and MEM guarantees they are cleared for invalid instructions.
  - retire_cnt increments by popcount(mem_valid).
- hold: condition is stall[STAGE]=1 and stall[STAGE+1]=1. All outputs and counters keep their values.
- Counters wrap modulo 2^CNT_W with no saturation.

Decomposition:
- Shared defines header, existing file: RstEnable, Stop/NoStop, ZeroWord, NOPRegAddr, True/False.
- Add CP0AddrBus (4:0) to the shared defines header.
- One natural sub-module: wb_conflict_resolve. It is combinational and takes valid, wreg and addr for LANES lanes, returning the masked wreg.
- The counters stay inline.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all inputs nonzero -> every output is 0 and retire_cnt=bubble_cnt=0.
- Advance (LANES=2): valid=2'b11, wreg=2'b11, addr={5'd9,5'd8}, data={32'hB,32'hA} -> next cycle wb_wreg=2'b11 with matching addr/data; retire_cnt=2.
- Conflict and $0: addr={5'd7,5'd7}, both lanes writing -> wb_wreg=2'b10. Then addr={5'd0,5'd3} -> wb_wreg=2'b01.
- Stall: stall=6'b010000 -> wb_* cleared and bubble_cnt+1. Then stall=6'b110000 -> outputs and both counters held.
- Flush: flush=1 with stall=6'b110000 and valid data present -> outputs cleared; retire_cnt and bubble_cnt unchanged.
- LLbit and wrap: mem_llbit_we=1, data=1 -> wb_llbit_we=1, wb_llbit_data=1. With CNT_W=4 and retire_cnt=15, one valid advance -> retire_cnt=0.

Source files
------------

// File: rtl/wb_stage_reg_pkg.sv
// Shared definitions for the MEM/WB pipeline register: the common
// reset/stall/zero constants and the per-edge action decode type.
package wb_stage_reg_pkg;

  localparam logic        RST_ENABLE     = 1'b1;
  localparam logic        STOP           = 1'b1;
  localparam logic        NO_STOP        = 1'b0;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR   = 5'b00000;
  localparam logic        TRUE_V         = 1'b1;
  localparam logic        FALSE_V        = 1'b0;
  localparam int          CP0_ADDR_BUS_W = 5;

  // What the stage register does on the coming posedge, highest priority first.
  typedef enum logic [2:0] {
    ACT_RST     = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_BUBBLE  = 3'd2,
    ACT_ADVANCE = 3'd3,
    ACT_HOLD    = 3'd4
  } wb_action_e;

endpackage

// File: rtl/wb_stage_reg_conflict_resolve.sv
// Combinational GPR write-enable masking for the writeback lanes.
// A lane writes only if it is valid, enabled and not targeting $0; when two
// writing lanes hit the same register, the older one is masked so the
// youngest lane (highest index) owns the write.
module wb_conflict_resolve
  import wb_stage_reg_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int ADDR_W = 5
) (
  input  logic [LANES-1:0]        valid,
  input  logic [LANES-1:0]        wreg,
  input  logic [LANES*ADDR_W-1:0] addr,
  output logic [LANES-1:0]        wreg_out
);

  // Gate each lane, then drop it if any younger lane writes the same register.
  always_comb begin
    wreg_out = '0;
    for (int i = 0; i < LANES; i++) begin
      wreg_out[i] = valid[i] & wreg[i] &
                    (addr[i*ADDR_W +: ADDR_W] != ADDR_W'(NOP_REG_ADDR));
      for (int j = i + 1; j < LANES; j++) begin
        if (valid[j] && wreg[j] &&
            (addr[j*ADDR_W +: ADDR_W] == addr[i*ADDR_W +: ADDR_W])) begin
          wreg_out[i] = FALSE_V;
        end
      end
    end
  end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with LANES GPR write lanes plus HI/LO, LLbit and
// CP0 write fields. Handles flush, bubble insertion and hold from the ctrl
// stall vector, and counts retired instructions and inserted bubbles.
module wb_stage_reg
  import wb_stage_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int LANES   = 1,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int CNT_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STALL_W-1:0]          stall,
  input  logic                        flush,
  input  logic [LANES-1:0]            mem_valid,
  input  logic [LANES-1:0]            mem_wreg,
  input  logic [LANES*ADDR_W-1:0]     mem_dest_addr,
  input  logic [LANES*DATA_W-1:0]     mem_dest_data,
  input  logic                        mem_whilo,
  input  logic [DATA_W-1:0]           mem_hi,
  input  logic [DATA_W-1:0]           mem_lo,
  input  logic                        mem_llbit_we,
  input  logic                        mem_llbit_data,
  input  logic                        mem_cp0_we,
  input  logic [CP0_ADDR_BUS_W-1:0]   mem_cp0_addr,
  input  logic [DATA_W-1:0]           mem_cp0_data,
  output logic [LANES-1:0]            wb_valid,
  output logic [LANES-1:0]            wb_wreg,
  output logic [LANES*ADDR_W-1:0]     wb_dest_addr,
  output logic [LANES*DATA_W-1:0]     wb_dest_data,
  output logic                        wb_whilo,
  output logic [DATA_W-1:0]           wb_hi,
  output logic [DATA_W-1:0]           wb_lo,
  output logic                        wb_llbit_we,
  output logic                        wb_llbit_data,
  output logic                        wb_cp0_we,
  output logic [CP0_ADDR_BUS_W-1:0]   wb_cp0_addr,
  output logic [DATA_W-1:0]           wb_cp0_data,
  output logic [CNT_W-1:0]            retire_cnt,
  output logic [CNT_W-1:0]            bubble_cnt
);

  wb_action_e         action;
  logic [LANES-1:0]   wreg_resolved;
  logic [CNT_W-1:0]   retire_inc;
  logic               stall_here;
  logic               stall_next;
  logic               unused_stall;

  assign stall_here   = stall[STAGE];
  assign stall_next   = stall[STAGE+1];
  // Only two bits of the stall vector matter to this stage.
  assign unused_stall = ^stall;

  wb_conflict_resolve #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_conflict (
    .valid    (mem_valid),
    .wreg     (mem_wreg),
    .addr     (mem_dest_addr),
    .wreg_out (wreg_resolved)
  );

  // Decode the action for this edge; flush outranks every stall combination.
  always_comb begin
    action = ACT_HOLD;
    if (rst == RST_ENABLE) begin
      action = ACT_RST;
    end else if (flush == TRUE_V) begin
      action = ACT_FLUSH;
    end else if (stall_here == STOP && stall_next == NO_STOP) begin
      action = ACT_BUBBLE;
    end else if (stall_here == NO_STOP) begin
      action = ACT_ADVANCE;
    end
  end

  // Number of real instructions entering WB this cycle.
  always_comb begin
    retire_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      retire_inc = retire_inc + CNT_W'(mem_valid[i]);
    end
  end

  // Pipeline register: clear on rst/flush/bubble, capture on advance, else hold.
  always_ff @(posedge clk) begin
    case (action)
      ACT_RST, ACT_FLUSH, ACT_BUBBLE: begin
        wb_valid      <= '0;
        wb_wreg       <= '0;
        wb_dest_addr  <= '0;
        wb_dest_data  <= '0;
        wb_whilo      <= FALSE_V;
        wb_hi         <= DATA_W'(ZERO_WORD);
        wb_lo         <= DATA_W'(ZERO_WORD);
        wb_llbit_we   <= FALSE_V;
        wb_llbit_data <= FALSE_V;
        wb_cp0_we     <= FALSE_V;
        wb_cp0_addr   <= '0;
        wb_cp0_data   <= DATA_W'(ZERO_WORD);
      end
      ACT_ADVANCE: begin
        wb_valid      <= mem_valid;
        wb_wreg       <= wreg_resolved;
        wb_dest_addr  <= mem_dest_addr;
        wb_dest_data  <= mem_dest_data;
        wb_whilo      <= mem_whilo;
        wb_hi         <= mem_hi;
        wb_lo         <= mem_lo;
        wb_llbit_we   <= mem_llbit_we;
        wb_llbit_data <= mem_llbit_data;
        wb_cp0_we     <= mem_cp0_we;
        wb_cp0_addr   <= mem_cp0_addr;
        wb_cp0_data   <= mem_cp0_data;
      end
      default: begin
      end
    endcase
  end

  // Retire and bubble counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    case (action)
      ACT_RST: begin
        retire_cnt <= '0;
        bubble_cnt <= '0;
      end
      ACT_BUBBLE: begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
      ACT_ADVANCE: begin
        retire_cnt <= retire_cnt + retire_inc;
      end
      default: begin
      end
    endcase
  end

endmodule
